// File: rtl/vx_fetch_ibuffer.sv
// Receiving end of the fetch interface: steers each fetched packet into a per-issue-slot
// FIFO chosen by the low wid bits and returns one registered ibuf_pop pulse per dequeue.
module vx_fetch_ibuffer #(
  parameter int THREAD_CNT     = 4,
  parameter int ISSUE_CNT      = 2,
  parameter int WARP_CNT_WIDTH = 2,
  parameter int UUID_W         = 1,
  parameter int XLEN           = 32,
  parameter int DEPTH          = 4,
  localparam int DATA_W        = UUID_W + WARP_CNT_WIDTH + THREAD_CNT + XLEN + 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          fetch_valid,
  input  logic [DATA_W-1:0]             fetch_data,
  output logic                          fetch_ready,
  output logic [ISSUE_CNT-1:0]          ibuf_pop,
  output logic [ISSUE_CNT-1:0]          out_valid,
  output logic [ISSUE_CNT*DATA_W-1:0]   out_data,
  input  logic [ISSUE_CNT-1:0]          out_ready
);

  localparam int ISSUE_BITS = (ISSUE_CNT > 1) ? $clog2(ISSUE_CNT) : 1;
  localparam int PTR_W      = $clog2(DEPTH);
  localparam int CNT_W      = $clog2(DEPTH + 1);
  localparam int WID_LSB    = XLEN + 32 + THREAD_CNT;

  logic [ISSUE_BITS-1:0] w_slot;
  logic [ISSUE_CNT-1:0]  w_sel;
  logic [ISSUE_CNT-1:0]  w_full;
  logic                  w_accept;

  assign w_slot = fetch_data[WID_LSB +: ISSUE_BITS];

  // Readiness depends only on the targeted slot, so a full slot never blocks the others.
  assign fetch_ready = reset_n && ((w_sel & w_full) == '0);
  assign w_accept    = fetch_valid && fetch_ready;

  for (genvar gi = 0; gi < ISSUE_CNT; gi++) begin : g_slot
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_pop;
    logic              w_push;
    logic              w_pop;

    assign w_sel[gi]  = (ISSUE_CNT == 1) ? 1'b1 : (w_slot == ISSUE_BITS'(gi));
    assign w_full[gi] = (r_count == CNT_W'(DEPTH));
    assign w_push     = w_accept && w_sel[gi];
    assign w_pop      = (r_count != '0) && out_ready[gi];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int k = 0; k < DEPTH; k++) begin
          r_mem[k] <= '0;
        end
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
        r_pop   <= 1'b0;
      end else begin
        if (w_push) begin
          r_mem[r_wptr] <= fetch_data;
          r_wptr        <= r_wptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + PTR_W'(1);
        end
        r_pop <= w_pop;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end

    // Head comes straight from storage, so it holds while the consumer stalls.
    assign out_valid[gi]                     = (r_count != '0);
    assign out_data[gi*DATA_W +: DATA_W]     = r_mem[r_rptr];
    assign ibuf_pop[gi]                      = r_pop;

    a_no_push_full: assert property (@(posedge clk) disable iff (!reset_n)
      w_push |-> (r_count != CNT_W'(DEPTH)));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset_n)
      w_pop |-> (r_count != '0));
    a_head_stable: assert property (@(posedge clk) disable iff (!reset_n)
      (out_valid[gi] && !out_ready[gi]) |=> $stable(out_data[gi*DATA_W +: DATA_W]));
  end

endmodule
